// File: rtl/mealy_run_gate_pkg.sv
// Shared state encoding and helpers for the Mealy run-gating controller.
// Code 2'd3 is unused and steers back to ST_IDLE.
package mealy_run_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } gate_state_t;

    function automatic logic isHoldState(input gate_state_t s);
        return s == ST_HOLD;
    endfunction

endpackage

// File: rtl/mealy_run_gate_nbit_register.sv
// WIDTH-bit D/Q register with load enable and async active-high reset.
// Reset value is a parameter so one cell serves both count and limit.
module nbit_register #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mealy_run_gate.sv
// Mealy run gate: forwards RunIN while the latched limit is not reached,
// with wrap/hold terminal handling, clear, done pulse and count visibility.
module mealy_run_gate
    import mealy_run_gate_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit WRAP_MODE = 1'b1
) (
    input  logic             CLK,
    input  logic             ResetIN,
    input  logic             RunIN,
    input  logic             ClearIN,
    input  logic [WIDTH-1:0] LimitIN,
    output logic             RunOUT,
    output logic             ResetOUT,
    output logic [WIDTH-1:0] CountOUT,
    output logic             DoneOUT,
    output logic             HoldOUT
);

    gate_state_t      state;
    gate_state_t      stateNext;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] countNext;
    logic [WIDTH-1:0] limitQ;
    logic             countEn;
    logic             limitEn;
    logic             doneNext;
    logic             term;

    nbit_register #(.WIDTH(WIDTH), .RST_VAL('0)) countReg (
        .clk (CLK),
        .rst (ResetIN),
        .en  (countEn),
        .d   (countNext),
        .q   (count)
    );

    nbit_register #(.WIDTH(WIDTH), .RST_VAL({WIDTH{1'b1}})) limitReg (
        .clk (CLK),
        .rst (ResetIN),
        .en  (limitEn),
        .d   (LimitIN),
        .q   (limitQ)
    );

    // In IDLE the limit is not latched yet, so look at the live input.
    assign term = (state == ST_IDLE) ? (LimitIN == '0)
                                     : (count == limitQ);

    assign RunOUT   = RunIN & ~term & ~isHoldState(state) & ~ResetIN;
    assign ResetOUT = ResetIN;
    assign CountOUT = count;
    assign HoldOUT  = isHoldState(state);

    always_comb begin
        stateNext = state;
        countNext = count;
        countEn   = 1'b0;
        limitEn   = 1'b0;
        doneNext  = 1'b0;
        if (ClearIN) begin
            stateNext = ST_IDLE;
            countNext = '0;
            countEn   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (RunIN) begin
                        limitEn   = 1'b1;
                        stateNext = ST_COUNT;
                        countEn   = 1'b1;
                        if (term) begin
                            doneNext  = 1'b1;
                            countNext = '0;
                            if (!WRAP_MODE) stateNext = ST_HOLD;
                        end else begin
                            countNext = WIDTH'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (RunIN) begin
                        countEn = 1'b1;
                        if (term) begin
                            doneNext = 1'b1;
                            if (WRAP_MODE) begin
                                countNext = '0;
                            end else begin
                                countEn   = 1'b0;
                                stateNext = ST_HOLD;
                            end
                        end else begin
                            countNext = count + WIDTH'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    stateNext = ST_HOLD;
                end
                default: begin
                    stateNext = ST_IDLE;
                    countNext = '0;
                    countEn   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ResetIN) begin
        if (ResetIN) begin
            state   <= ST_IDLE;
            DoneOUT <= 1'b0;
        end else begin
            state   <= stateNext;
            DoneOUT <= doneNext;
        end
    end

endmodule

// File: tb/tb_mealy_run_gate.sv
// Directed bench: instance A is the 2-bit wrapping gate, instance B the
// 4-bit stop-in-HOLD gate; expected values are hand-derived constants.
module tb_mealy_run_gate;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       resetA, runA, clearA;
    logic [1:0] limitA;
    logic       runOutA, resetOutA, doneA, holdA;
    logic [1:0] countA;

    logic       resetB, runB, clearB;
    logic [3:0] limitB;
    logic       runOutB, resetOutB, doneB, holdB;
    logic [3:0] countB;

    always #5 clk = ~clk;

    mealy_run_gate #(.WIDTH(2), .WRAP_MODE(1'b1)) dutA (
        .CLK      (clk),
        .ResetIN  (resetA),
        .RunIN    (runA),
        .ClearIN  (clearA),
        .LimitIN  (limitA),
        .RunOUT   (runOutA),
        .ResetOUT (resetOutA),
        .CountOUT (countA),
        .DoneOUT  (doneA),
        .HoldOUT  (holdA)
    );

    mealy_run_gate #(.WIDTH(4), .WRAP_MODE(1'b0)) dutB (
        .CLK      (clk),
        .ResetIN  (resetB),
        .RunIN    (runB),
        .ClearIN  (clearB),
        .LimitIN  (limitB),
        .RunOUT   (runOutB),
        .ResetOUT (resetOutB),
        .CountOUT (countB),
        .DoneOUT  (doneB),
        .HoldOUT  (holdB)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clearBoth();
        runA = 0; runB = 0;
        clearA = 1; clearB = 1;
        cyc();
        clearA = 0; clearB = 0;
    endtask

    task automatic test_reset();
        resetA = 1; resetB = 1;
        runA = 1; runB = 1;
        clearA = 0; clearB = 0;
        limitA = 2'd3; limitB = 4'd5;
        cyc();
        checks++;
        if (runOutA !== 1'b0 || resetOutA !== 1'b1) begin
            errors++;
            $display("FAIL reset_outs_A run=%b rst=%b want 0 1", runOutA, resetOutA);
        end
        checks++;
        if (countA !== 2'd0 || doneA !== 1'b0 || holdA !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_A cnt=%0d done=%b hold=%b want 0 0 0",
                     countA, doneA, holdA);
        end
        checks++;
        if (runOutB !== 1'b0 || resetOutB !== 1'b1 || countB !== 4'd0 ||
            doneB !== 1'b0 || holdB !== 1'b0) begin
            errors++;
            $display("FAIL reset_B run=%b rst=%b cnt=%0d done=%b hold=%b want 0 1 0 0 0",
                     runOutB, resetOutB, countB, doneB, holdB);
        end
        runA = 0; runB = 0;
        resetA = 0; resetB = 0;
        #1;
        checks++;
        if (resetOutA !== 1'b0 || resetOutB !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rstA=%b rstB=%b want 0 0", resetOutA, resetOutB);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] er;
        logic [7:0] ed;
        logic [1:0] ec [8];
        er = 8'b0111_0111;
        ed = 8'b1000_1000;
        ec = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        limitA = 2'd3;
        for (int i = 0; i < 8; i++) begin
            runA = 1;
            #1;
            checks++;
            if (runOutA !== er[i]) begin
                errors++;
                $display("FAIL wrap_run cyc%0d got %b want %b", i + 1, runOutA, er[i]);
            end
            cyc();
            checks++;
            if (countA !== ec[i] || doneA !== ed[i]) begin
                errors++;
                $display("FAIL wrap_cnt edge%0d cnt=%0d done=%b want %0d %b",
                         i + 1, countA, doneA, ec[i], ed[i]);
            end
        end
        runA = 0;
        cyc();
        checks++;
        if (countA !== 2'd0 || doneA !== 1'b0 || holdA !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle cnt=%0d done=%b hold=%b want 0 0 0",
                     countA, doneA, holdA);
        end
        clearBoth();
    endtask

    task automatic test_hold();
        logic [7:0] er;
        logic [7:0] eh;
        logic [7:0] ed;
        logic [3:0] ec [8];
        er = 8'b0001_1111;
        eh = 8'b1110_0000;
        ed = 8'b0010_0000;
        ec = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
        limitB = 4'd5;
        for (int i = 0; i < 8; i++) begin
            runB = 1;
            #1;
            checks++;
            if (runOutB !== er[i]) begin
                errors++;
                $display("FAIL hold_run cyc%0d got %b want %b", i + 1, runOutB, er[i]);
            end
            cyc();
            checks++;
            if (countB !== ec[i] || holdB !== eh[i] || doneB !== ed[i]) begin
                errors++;
                $display("FAIL hold_state edge%0d cnt=%0d hold=%b done=%b want %0d %b %b",
                         i + 1, countB, holdB, doneB, ec[i], eh[i], ed[i]);
            end
        end
        clearB = 1;
        #1;
        checks++;
        if (runOutB !== 1'b0) begin
            errors++;
            $display("FAIL hold_clear_run got %b want 0", runOutB);
        end
        cyc();
        clearB = 0;
        checks++;
        if (countB !== 4'd0 || holdB !== 1'b0 || doneB !== 1'b0) begin
            errors++;
            $display("FAIL hold_clear cnt=%0d hold=%b done=%b want 0 0 0",
                     countB, holdB, doneB);
        end
        #1;
        checks++;
        if (runOutB !== 1'b1) begin
            errors++;
            $display("FAIL hold_follow_hi got %b want 1", runOutB);
        end
        runB = 0;
        #1;
        checks++;
        if (runOutB !== 1'b0) begin
            errors++;
            $display("FAIL hold_follow_lo got %b want 0", runOutB);
        end
    endtask

    task automatic test_limit_zero();
        limitA = 2'd0;
        for (int i = 0; i < 3; i++) begin
            runA = 1;
            #1;
            checks++;
            if (runOutA !== 1'b0) begin
                errors++;
                $display("FAIL lz_wrap_run pulse%0d got %b want 0", i, runOutA);
            end
            cyc();
            checks++;
            if (countA !== 2'd0 || doneA !== 1'b1 || holdA !== 1'b0) begin
                errors++;
                $display("FAIL lz_wrap_done pulse%0d cnt=%0d done=%b hold=%b want 0 1 0",
                         i, countA, doneA, holdA);
            end
            runA = 0;
            cyc();
            checks++;
            if (doneA !== 1'b0) begin
                errors++;
                $display("FAIL lz_wrap_drop pulse%0d done=%b want 0", i, doneA);
            end
        end
        limitB = 4'd0;
        runB = 1;
        #1;
        checks++;
        if (runOutB !== 1'b0) begin
            errors++;
            $display("FAIL lz_hold_run got %b want 0", runOutB);
        end
        cyc();
        checks++;
        if (holdB !== 1'b1 || doneB !== 1'b1 || countB !== 4'd0) begin
            errors++;
            $display("FAIL lz_hold hold=%b done=%b cnt=%0d want 1 1 0",
                     holdB, doneB, countB);
        end
        runB = 0;
        cyc();
        runB = 1;
        cyc();
        checks++;
        if (holdB !== 1'b1 || doneB !== 1'b0 || runOutB !== 1'b0) begin
            errors++;
            $display("FAIL lz_hold_stay hold=%b done=%b run=%b want 1 0 0",
                     holdB, doneB, runOutB);
        end
        clearBoth();
    endtask

    task automatic test_reset_mid();
        limitA = 2'd3;
        runA = 1;
        repeat (3) cyc();
        checks++;
        if (countA !== 2'd3) begin
            errors++;
            $display("FAIL rmid_pre cnt=%0d want 3", countA);
        end
        #2;
        resetA = 1;
        #1;
        checks++;
        if (countA !== 2'd0 || doneA !== 1'b0 || resetOutA !== 1'b1 || runOutA !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async cnt=%0d done=%b rst=%b run=%b want 0 0 1 0",
                     countA, doneA, resetOutA, runOutA);
        end
        cyc();
        runA = 0;
        resetA = 0;
        #1;
        checks++;
        if (resetOutA !== 1'b0 || countA !== 2'd0 || doneA !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release rst=%b cnt=%0d done=%b want 0 0 0",
                     resetOutA, countA, doneA);
        end
    endtask

    task automatic test_clear_priority();
        limitA = 2'd3;
        runA = 1;
        repeat (3) cyc();
        clearA = 1;
        #1;
        checks++;
        if (runOutA !== 1'b0 || countA !== 2'd3) begin
            errors++;
            $display("FAIL clr_pre run=%b cnt=%0d want 0 3", runOutA, countA);
        end
        cyc();
        clearA = 0;
        checks++;
        if (countA !== 2'd0 || doneA !== 1'b0 || holdA !== 1'b0) begin
            errors++;
            $display("FAIL clr_win cnt=%0d done=%b hold=%b want 0 0 0",
                     countA, doneA, holdA);
        end
        cyc();
        checks++;
        if (doneA !== 1'b0 || countA !== 2'd1) begin
            errors++;
            $display("FAIL clr_restart done=%b cnt=%0d want 0 1", doneA, countA);
        end
        clearBoth();
    endtask

    task automatic test_limit_change();
        limitB = 4'd5;
        runB = 1;
        repeat (3) cyc();
        limitB = 4'd2;
        repeat (2) cyc();
        checks++;
        if (countB !== 4'd5 || holdB !== 1'b0) begin
            errors++;
            $display("FAIL lchg_old cnt=%0d hold=%b want 5 0", countB, holdB);
        end
        checks++;
        if (runOutB !== 1'b0) begin
            errors++;
            $display("FAIL lchg_term run=%b want 0", runOutB);
        end
        cyc();
        checks++;
        if (holdB !== 1'b1 || doneB !== 1'b1) begin
            errors++;
            $display("FAIL lchg_hold hold=%b done=%b want 1 1", holdB, doneB);
        end
        clearBoth();
        runB = 1;
        repeat (2) cyc();
        checks++;
        if (countB !== 4'd2 || runOutB !== 1'b0) begin
            errors++;
            $display("FAIL lchg_new cnt=%0d run=%b want 2 0", countB, runOutB);
        end
        cyc();
        checks++;
        if (holdB !== 1'b1 || countB !== 4'd2 || doneB !== 1'b1) begin
            errors++;
            $display("FAIL lchg_new_hold hold=%b cnt=%0d done=%b want 1 2 1",
                     holdB, countB, doneB);
        end
        clearBoth();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hold();
        test_limit_zero();
        test_reset_mid();
        test_clear_priority();
        test_limit_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
